din_packer: RTL and testbench
=============================

Name: din_packer

Overview:
- Transmitter for the DUT's din channel: the producer end of the busy/vld point-to-point interface that the DUT's din port consumes.
- Accepts a serial byte stream and assembles each group of 8 bytes into one din transfer on lanes din_data_a..din_data_h, then drives it to the DUT.
- Sits between the stimulus/byte source and the DUT din port, in both the cosim wrapper and the synthesized test harness.

Parameters:
- DATA_W, 8, lane width in bits. All din_data_* lanes and in_data use this width.
- CNT_W, 16, width of the frame_cnt counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_vld  in  1  upstream byte valid.
- in_data  in  DATA_W  upstream byte.
- in_sof  in  1  start-of-frame marker, qualified by in_vld.
- in_busy  out  1  upstream must hold its byte.
- din_vld  out  1  frame valid toward the DUT.
- din_data_a .. din_data_h  out  DATA_W each  frame lanes; lane a is the first byte received.
- din_busy  in  1  DUT cannot accept.
- frame_cnt  out  CNT_W  count of frames delivered to the DUT.
- drop_pulse  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Handshake, both sides: a transfer occurs on the rising edge where vld=1 and busy=0. The producer holds vld and data stable until that transfer completes.
- Reset (rst=0, asynchronous): byte count=0, din_vld=0, all din_data_*=0, frame_cnt=0, drop_pulse=0, out_full=0. The assembly registers clear to 0. in_busy therefore reads 0.
- Reset mid-frame: the partial frame and any pending output frame are lost. No drop_pulse is generated.
- State: byte count cnt (0..7); assembly registers for lanes a..g; output register for all 8 lanes; out_full (equal to din_vld).
- Byte accept: occurs when in_vld=1 and in_busy=0.
  - cnt<7: store the byte in lane[cnt], then cnt+1.
  - cnt==7: the 8th byte. At that edge, load the output register with {a..g held, in_data as lane h}, set din_vld=1, and set cnt=0.
- in_busy = (cnt==7) & out_full & din_busy. It is combinational from din_busy.
  - The 8th byte may be loaded on the same edge the previous frame is accepted; back-to-back full throughput is 1 frame per 8 cycles.
  - in_busy is never asserted while cnt<7.
- Latency: din_vld rises on the edge that accepts byte 8, i.e. visible 1 cycle after that byte is presented.
- Output accept (din_vld & !din_busy):
  - frame_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - din_vld clears unless a new frame loads on the same edge, in which case it stays 1 with the new data.
- din_data_* hold the last frame's values after din_vld falls. They change only on a load.
- in_sof on an accepted byte:
  - The byte is written as lane a and cnt becomes 1, regardless of the prior cnt.
  - If prior cnt != 0, drop_pulse=1 for exactly the following cycle, and the partial bytes are discarded.
  - sof with prior cnt==0: normal, no pulse.
  - sof while cnt==7 and in_busy=1: not accepted, no effect until accepted.
- in_sof with in_vld=0 is ignored.
- Simultaneous events: output accept plus 8th-byte load on the same edge → frame_cnt+1, din_vld stays 1, data becomes the new frame.

Test Plan:
- Reset, then 8 bytes 0x01..0x08 with din_busy=0 → din_vld high for 1 cycle; a=0x01 … h=0x08; frame_cnt=1; in_busy never 1.
- Continuous stream 0x00..0x1F, din_busy=0 → 4 frames, one every 8 cycles; frame 3 lanes = 0x10..0x17; frame_cnt=4.
- Hold din_busy=1 after frame 1 and send 8 more bytes →
  - bytes 1–7 accepted, in_busy=1 while byte 8 is presented, din_data stays 0x01..0x08;
  - release din_busy → on that edge frame 1 is counted and frame 2 loads; din_vld stays 1.
- Send 0xAA,0xBB,0xCC, then 0x11 with in_sof, then 7 more bytes 0x12..0x18 →
  - drop_pulse for 1 cycle;
  - the frame delivered is a=0x11 … h=0x18; 0xAA..0xCC never appear.
- Assert rst=0 after 5 bytes with a frame pending on din_busy=1 → din_vld=0, all lanes 0, frame_cnt=0 immediately (asynchronously); the next 8 bytes form a clean frame.
- Preload frame_cnt to 0xFFFF via 65535 frames (or forced) and deliver 1 more → frame_cnt=0x0000.

Source files
------------

// File: rtl/din_packer.sv
// Producer for the DUT din channel: packs a serial byte stream into 8-lane frames
// and hands each frame over a vld/busy handshake, counting delivered frames.
module din_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              in_busy,
    output logic              din_vld,
    output logic [DATA_W-1:0] din_data_a,
    output logic [DATA_W-1:0] din_data_b,
    output logic [DATA_W-1:0] din_data_c,
    output logic [DATA_W-1:0] din_data_d,
    output logic [DATA_W-1:0] din_data_e,
    output logic [DATA_W-1:0] din_data_f,
    output logic [DATA_W-1:0] din_data_g,
    output logic [DATA_W-1:0] din_data_h,
    input  logic              din_busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              drop_pulse
);

    localparam int unsigned LANES = 8;
    localparam int unsigned CW    = 3;

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] asm_q [LANES-1];
    logic [DATA_W-1:0] out_q [LANES];
    logic              out_full;

    logic last;
    logic in_acc;
    logic out_acc;
    logic load;

    // Upstream stalls only when byte 8 would overwrite a frame the DUT still refuses.
    assign last    = (cnt == CW'(LANES - 1));
    assign in_busy = last & out_full & din_busy;
    assign in_acc  = in_vld & ~in_busy;
    assign out_acc = out_full & ~din_busy;
    assign load    = in_acc & ~in_sof & last;

    // Byte counter and assembly lanes a..g; sof restarts the frame at lane a.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int unsigned i = 0; i < LANES - 1; i++) asm_q[i] <= '0;
        end else if (in_acc) begin
            if (in_sof) begin
                asm_q[0] <= in_data;
                cnt      <= CW'(1);
            end else if (last) begin
                cnt <= '0;
            end else begin
                asm_q[cnt] <= in_data;
                cnt        <= cnt + CW'(1);
            end
        end
    end

    // Output frame register; a load may coincide with acceptance of the previous frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_full <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) out_q[i] <= '0;
        end else if (load) begin
            out_full <= 1'b1;
            for (int unsigned i = 0; i < LANES - 1; i++) out_q[i] <= asm_q[i];
            out_q[LANES-1] <= in_data;
        end else if (out_acc) begin
            out_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            if (out_acc) frame_cnt <= frame_cnt + CNT_W'(1);
            drop_pulse <= in_acc & in_sof & (cnt != '0);
        end
    end

    assign din_vld    = out_full;
    assign din_data_a = out_q[0];
    assign din_data_b = out_q[1];
    assign din_data_c = out_q[2];
    assign din_data_d = out_q[3];
    assign din_data_e = out_q[4];
    assign din_data_f = out_q[5];
    assign din_data_g = out_q[6];
    assign din_data_h = out_q[7];

endmodule

// File: tb/tb_din_packer.sv
// Directed bench for din_packer: per-cycle vector table plus hand sequences for
// stall/sof corners and asynchronous reset; a 3-bit counter copy exercises wrap.
module tb_din_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_data;
    logic       in_sof;
    logic       din_busy;

    logic        in_busy, din_vld, drop_pulse;
    logic [7:0]  la, lb, lc, ld, le, lf, lg, lh;
    logic [15:0] frame_cnt;
    logic [63:0] lanes;

    logic        s_in_busy, s_din_vld, s_drop;
    logic [7:0]  sa, sb, sc, sd, se, sf, sg, sh;
    logic [2:0]  s_fcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign lanes = {la, lb, lc, ld, le, lf, lg, lh};

    din_packer dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_sof(in_sof),
        .in_busy(in_busy), .din_vld(din_vld),
        .din_data_a(la), .din_data_b(lb), .din_data_c(lc), .din_data_d(ld),
        .din_data_e(le), .din_data_f(lf), .din_data_g(lg), .din_data_h(lh),
        .din_busy(din_busy), .frame_cnt(frame_cnt), .drop_pulse(drop_pulse)
    );

    din_packer #(.DATA_W(8), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_sof(in_sof),
        .in_busy(s_in_busy), .din_vld(s_din_vld),
        .din_data_a(sa), .din_data_b(sb), .din_data_c(sc), .din_data_d(sd),
        .din_data_e(se), .din_data_f(sf), .din_data_g(sg), .din_data_h(sh),
        .din_busy(din_busy), .frame_cnt(s_fcnt), .drop_pulse(s_drop)
    );

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        sof;
        logic        dbusy;
        logic        e_ibusy;
        logic        e_dvld;
        logic        e_drop;
        logic [15:0] e_fcnt;
        logic [63:0] e_lanes;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic vld, logic [7:0] data, logic sof, logic dbusy,
                                logic eib, logic edv, logic edr,
                                logic [15:0] efc, logic [63:0] eln);
        vec_t v;
        v.vld = vld; v.data = data; v.sof = sof; v.dbusy = dbusy;
        v.e_ibusy = eib; v.e_dvld = edv; v.e_drop = edr;
        v.e_fcnt = efc; v.e_lanes = eln;
        return v;
    endfunction

    // Frame of 8 consecutive byte values starting at b, lane a first.
    function automatic logic [63:0] frame_of(logic [7:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], 8'(b + 8'(i))};
        return r;
    endfunction

    task automatic chk(string name, int id, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (vec %0d): got %h want %h", name, id, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check in_busy, clock, check state.
    task automatic run_vec(vec_t v, int id);
        in_vld = v.vld; in_data = v.data; in_sof = v.sof; din_busy = v.dbusy;
        #1;
        chk("in_busy", id, 64'(in_busy), 64'(v.e_ibusy));
        @(posedge clk);
        #1;
        chk("din_vld", id, 64'(din_vld), 64'(v.e_dvld));
        chk("drop_pulse", id, 64'(drop_pulse), 64'(v.e_drop));
        chk("frame_cnt", id, 64'(frame_cnt), 64'(v.e_fcnt));
        chk("lanes", id, lanes, v.e_lanes);
        chk("frame_cnt_w3", id, 64'(s_fcnt), 64'(v.e_fcnt[2:0]));
    endtask

    task automatic idle_inputs();
        in_vld = 1'b0; in_data = 8'h00; in_sof = 1'b0;
    endtask

    initial begin
        logic [63:0] f1, f2, f3, f4, f5, f81, fa, f61, prev;
        int id;
        f1  = frame_of(8'h01); f2 = frame_of(8'h21); f3 = frame_of(8'h31);
        f4  = frame_of(8'h11); f5 = frame_of(8'h51); f81 = frame_of(8'h81);
        f61 = frame_of(8'h61);
        fa  = {8'h77, frame_of(8'hA2)};
        fa  = {8'h77, fa[63:8]};

        // Single frame 0x01..0x08 straight through.
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 8'(i + 1), 0, 0, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 8'h08, 0, 0, 0, 1, 0, 0, f1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, f1));
        // Frame 2 loads into a busy DUT; frame 3's last byte stalls, then both move on one edge.
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 8'(8'h21 + i), 0, 0, 0, 0, 0, 1, f1));
        tbl.push_back(mk(1, 8'h28, 0, 1, 0, 1, 0, 1, f2));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 8'(8'h31 + i), 0, 1, 0, 1, 0, 1, f2));
        tbl.push_back(mk(1, 8'h38, 0, 1, 1, 1, 0, 1, f2));
        tbl.push_back(mk(1, 8'h38, 0, 1, 1, 1, 0, 1, f2));
        tbl.push_back(mk(1, 8'h38, 0, 0, 0, 1, 0, 2, f3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 3, f3));
        // Partial frame dropped by sof.
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 3, f3));
        tbl.push_back(mk(1, 8'hBB, 0, 0, 0, 0, 0, 3, f3));
        tbl.push_back(mk(1, 8'hCC, 0, 0, 0, 0, 0, 3, f3));
        tbl.push_back(mk(1, 8'h11, 1, 0, 0, 0, 1, 3, f3));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 8'(8'h12 + i), 0, 0, 0, 0, 0, 3, f3));
        tbl.push_back(mk(1, 8'h18, 0, 0, 0, 1, 0, 3, f4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 4, f4));
        // sof at a frame boundary is not a drop; sof without vld is ignored.
        tbl.push_back(mk(1, 8'h51, 1, 0, 0, 0, 0, 4, f4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 4, f4));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 8'(8'h52 + i), 0, 0, 0, 0, 0, 4, f4));
        tbl.push_back(mk(1, 8'h58, 0, 0, 0, 1, 0, 4, f5));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 5, f5));
        // Continuous stream 0x00..0x1F: one frame every 8 cycles.
        for (int k = 0; k < 32; k++) begin
            prev = (k < 7) ? f5 : frame_of(8'(8 * ((k + 1) / 8 - 1)));
            tbl.push_back(mk(1, 8'(k), 0, 0, 0, (k % 8) == 7, 0, 16'(5 + k / 8), prev));
        end
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 9, frame_of(8'h18)));

        rst = 1'b0; din_busy = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_vld", 0, 64'(din_vld), 64'h0);
        chk("rst_lanes", 0, lanes, 64'h0);
        chk("rst_frame_cnt", 0, 64'(frame_cnt), 64'h0);
        chk("rst_drop", 0, 64'(drop_pulse), 64'h0);
        chk("rst_in_busy", 0, 64'(in_busy), 64'h0);
        rst = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Sof presented while the 8th slot is stalled has no effect until accepted.
        id = 1000;
        for (int i = 0; i < 7; i++) run_vec(mk(1, 8'(8'h81 + i), 0, 1, 0, 0, 0, 9, frame_of(8'h18)), id++);
        run_vec(mk(1, 8'h88, 0, 1, 0, 1, 0, 9, f81), id++);
        for (int i = 0; i < 7; i++) run_vec(mk(1, 8'(8'h91 + i), 0, 1, 0, 1, 0, 9, f81), id++);
        run_vec(mk(1, 8'h77, 1, 1, 1, 1, 0, 9, f81), id++);
        run_vec(mk(1, 8'h77, 1, 0, 0, 0, 1, 10, f81), id++);
        for (int i = 0; i < 6; i++) run_vec(mk(1, 8'(8'hA2 + i), 0, 1, 0, 0, 0, 10, f81), id++);
        run_vec(mk(1, 8'hA8, 0, 1, 0, 1, 0, 10, fa), id++);

        // Asynchronous reset mid-frame with a frame pending.
        for (int i = 0; i < 5; i++) run_vec(mk(1, 8'(8'hB1 + i), 0, 1, 0, 1, 0, 10, fa), id++);
        #3;
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("arst_din_vld", id, 64'(din_vld), 64'h0);
        chk("arst_lanes", id, lanes, 64'h0);
        chk("arst_frame_cnt", id, 64'(frame_cnt), 64'h0);
        chk("arst_frame_cnt_w3", id, 64'(s_fcnt), 64'h0);
        chk("arst_drop", id, 64'(drop_pulse), 64'h0);
        chk("arst_in_busy", id, 64'(in_busy), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        din_busy = 1'b0;
        for (int i = 0; i < 7; i++) run_vec(mk(1, 8'(8'h61 + i), 0, 0, 0, 0, 0, 0, 64'h0), id++);
        run_vec(mk(1, 8'h68, 0, 0, 0, 1, 0, 0, f61), id++);
        run_vec(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, f61), id++);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
